fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_fifo.sv | 104 ++++++++++
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch sequencer and its queue.
//   - fetch_state_t / ST_IDLE / ST_FETCH : sequencer FSM encoding
//   - QDEPTH_DEFAULT                     : default fetch queue depth
//   - PC_STEP                            : PC increment per fetched word
//   - INST_NOP                           : word shown on out_inst when empty
//   - fetch_entry_t                      : one queue entry {pc, inst}
//   - align_pc()                         : forces a target onto a word boundary
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef logic [0:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE  = 1'b0;
    localparam fetch_state_t ST_FETCH = 1'b1;

    localparam int          QDEPTH_DEFAULT = 2;
    localparam logic [31:0] PC_STEP        = 32'd4;
    localparam logic [31:0] INST_NOP       = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Redirect targets may carry stray low bits; fetches are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small circular queue holding fetched {pc, inst} entries between the fetch
// stage and the decoder. Push, pop and flush all act on the rising clock edge.
// Flush wins over push and pop: the queue is empty after a flush cycle.
//
// Ports
//   clk          : clock
//   rst          : asynchronous active-high reset (queue empty)
//   push_i       : write push_data_i at the tail
//   pop_i        : drop the head entry
//   flush_i      : discard every entry
//   push_data_i  : entry to write
//   head_o       : head entry (only meaningful while count_o != 0)
//   count_o      : number of valid entries
//   full_o       : count_o == DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = QDEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           push_data_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          empty;
    logic          push_eff;
    logic          pop_eff;

    fetch_entry_t  mem_q [DEPTH];

    assign empty  = (cnt_q == '0);
    assign full_o = (cnt_q == CNT_FULL);

    // A push into a full queue is only legal when the head leaves in the same
    // cycle; DEPTH is a power of two so the pointers wrap on their own.
    assign pop_eff  = pop_i && !empty;
    assign push_eff = push_i && (!full_o || pop_eff);

    // Next-state pointers and occupancy.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_eff) begin
                wr_d = wr_q + PTR_ONE;
            end
            if (pop_eff) begin
                rd_d = rd_q + PTR_ONE;
            end
            if (push_eff && !pop_eff) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (!push_eff && pop_eff) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the top masks the head whenever count is zero.
    always_ff @(posedge clk) begin
        if (push_eff && !flush_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction fetch front end. Walks a PC through instruction memory while
// fetching is enabled, pushes {pc, inst} into a small queue and hands the
// head entry to the decoder with a valid/ready handshake. A redirect flushes
// the queue and restarts fetching at the (word aligned) target next cycle.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   rst            : asynchronous active-high reset
//   fetch_en       : fetching permitted while high
//   imem_a         : instruction memory address (current PC)
//   imem_do        : combinational instruction memory data for imem_a
//   redirect_valid : branch/jump target presented this cycle
//   redirect_pc    : target address
//   out_valid      : head queue entry valid
//   out_ready      : decoder accepts the head entry this cycle
//   out_inst       : head entry instruction word (INST_NOP when empty)
//   out_pc         : head entry fetch address (zero when empty)
//   fetch_count    : saturating count of instructions pushed since reset
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = QDEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_do,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;
    localparam logic [31:0] COUNT_ONE = 32'd1;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_count_q, fetch_count_d;

    logic                    q_full;
    logic [$clog2(QDEPTH):0] q_count;
    fetch_entry_t            q_head;
    fetch_entry_t            q_push_data;
    logic                    dequeue;
    logic                    push_req;
    logic                    push;

    // The FSM only gates fetching; redirects are honoured in either state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (fetch_en)  state_d = ST_FETCH;
            ST_FETCH: if (!fetch_en) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    assign dequeue = out_valid && out_ready;

    // A full queue still accepts a push when its head leaves this cycle, which
    // keeps sustained throughput at one word per cycle. A redirect kills the
    // push so the wrong-path word never enters the queue or the counter.
    assign push_req = (state_q == ST_FETCH) && fetch_en && (!q_full || dequeue);
    assign push     = push_req && !redirect_valid;

    assign q_push_data.pc   = pc_q;
    assign q_push_data.inst = imem_do;

    // PC update: redirect first, otherwise step past the word just pushed.
    // Natural 32-bit overflow wraps 0xFFFFFFFC to 0x00000000.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (push && (fetch_count_q != COUNT_MAX)) begin
            fetch_count_d = fetch_count_q + COUNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // A same-cycle dequeue still completes from the decoder's point of view;
    // the flush then clears whatever remains.
    fetch_fifo #(
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (dequeue),
        .flush_i     (redirect_valid),
        .push_data_i (q_push_data),
        .head_o      (q_head),
        .count_o     (q_count),
        .full_o      (q_full)
    );

    assign imem_a      = pc_q;
    assign out_valid   = (q_count != '0);
    assign out_inst    = out_valid ? q_head.inst : INST_NOP;
    assign out_pc      = out_valid ? q_head.pc   : 32'h0000_0000;
    assign fetch_count = fetch_count_q;

endmodule
